// File: rtl/fractal_sync_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : fractal_sync_rr_arb
// Purpose  : Lets N_REQ compute-unit requesters share one fractal sync
//            request port. Each requester can hold one latched barrier
//            request. Queued requests go downstream in round-robin order.
//            Wake and error responses return to the requesters selected by a
//            destination mask. A per-requester watchdog turns a lost wake
//            into an error.
// Ports    : clk_i, rst_ni (async active-low)
//            req_sync_i/req_aggr_i/req_id_i  per-requester request (flat vectors)
//            req_wake_o/req_error_o          per-requester one-cycle pulses
//            out_sync_o/out_ready_i          downstream valid/ready
//            out_aggr_o/out_id_o/out_src_o   granted request fields
//            rsp_wake_i/rsp_error_i/rsp_dst_i downstream response + dst mask
// Revision : 1.0  initial release
// ============================================================================
module fractal_sync_rr_arb #(
    parameter int N_REQ          = 4,
    parameter int AGGR_W         = 6,
    parameter int ID_W           = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_REQ-1:0]           req_sync_i,
    input  logic [N_REQ*AGGR_W-1:0]    req_aggr_i,
    input  logic [N_REQ*ID_W-1:0]      req_id_i,
    output logic [N_REQ-1:0]           req_wake_o,
    output logic [N_REQ-1:0]           req_error_o,
    output logic                       out_sync_o,
    input  logic                       out_ready_i,
    output logic [AGGR_W-1:0]          out_aggr_o,
    output logic [ID_W-1:0]            out_id_o,
    output logic [$clog2(N_REQ)-1:0]   out_src_o,
    input  logic                       rsp_wake_i,
    input  logic                       rsp_error_i,
    input  logic [N_REQ-1:0]           rsp_dst_i
);

    localparam int SRC_W   = $clog2(N_REQ);
    // A disabled watchdog still gets a 1-bit counter so no vector has zero width.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_QUEUED = 2'd1;
    localparam logic [1:0] c_ST_ISSUED = 2'd2;

    logic [N_REQ-1:0]        w_queued;
    logic [N_REQ*AGGR_W-1:0] w_aggr_all;
    logic [N_REQ*ID_W-1:0]   w_id_all;
    logic                    w_found;
    logic [SRC_W-1:0]        w_win;
    logic [SRC_W:0]          w_idx;
    logic                    w_hs;
    logic [SRC_W-1:0]        r_ptr;

    // Round-robin search. It starts at r_ptr and wraps at N_REQ. The extra
    // index bit keeps ptr+i from overflowing before the wrap is applied.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + (SRC_W+1)'(i);
            if (w_idx >= (SRC_W+1)'(N_REQ)) begin
                w_idx = w_idx - (SRC_W+1)'(N_REQ);
            end
            if (!w_found && w_queued[w_idx[SRC_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[SRC_W-1:0];
            end
        end
    end

    assign w_hs       = w_found && out_ready_i;
    assign out_sync_o = w_found;
    assign out_src_o  = w_win;
    // The latched fields stay in their registers after use, so gate them
    // with w_found to give all-zero fields when nothing is queued.
    assign out_aggr_o = w_found ? w_aggr_all[w_win*AGGR_W +: AGGR_W] : '0;
    assign out_id_o   = w_found ? w_id_all[w_win*ID_W +: ID_W] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= (w_win == SRC_W'(N_REQ - 1)) ? '0 : w_win + SRC_W'(1);
        end
    end

    for (genvar k = 0; k < N_REQ; k++) begin : g_req
        logic [1:0]         r_state;
        logic [AGGR_W-1:0]  r_aggr;
        logic [ID_W-1:0]    r_id;
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_wake;
        logic               r_err;
        logic               w_grant;
        logic               w_hit_wake;
        logic               w_hit_err;
        logic               w_expired;

        assign w_grant    = w_hs && (w_win == SRC_W'(k));
        assign w_hit_err  = rsp_error_i && rsp_dst_i[k];
        assign w_hit_wake = rsp_wake_i && rsp_dst_i[k];
        // With the watchdog disabled, the counter sits at 0 == TIMEOUT_CYCLES.
        // That would look like an expiry, so the enable qualifies it.
        assign w_expired  = (TIMEOUT_CYCLES > 0) && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state <= c_ST_IDLE;
                r_aggr  <= '0;
                r_id    <= '0;
                r_cnt   <= '0;
                r_wake  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                r_wake <= 1'b0;
                r_err  <= 1'b0;
                // A second request while one is outstanding is dropped and
                // flagged. The FSM keeps tracking the original request.
                if (req_sync_i[k] && (r_state != c_ST_IDLE)) begin
                    r_err <= 1'b1;
                end
                case (r_state)
                    c_ST_IDLE: begin
                        if (req_sync_i[k]) begin
                            r_state <= c_ST_QUEUED;
                            r_aggr  <= req_aggr_i[k*AGGR_W +: AGGR_W];
                            r_id    <= req_id_i[k*ID_W +: ID_W];
                        end
                    end
                    c_ST_QUEUED: begin
                        if (w_grant) begin
                            r_state <= c_ST_ISSUED;
                            r_cnt   <= '0;
                        end
                    end
                    c_ST_ISSUED: begin
                        // Priority: downstream error, then wake, then the
                        // watchdog. A real response beats a same-cycle expiry.
                        if (w_hit_err) begin
                            r_err   <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else if (w_hit_wake) begin
                            r_wake  <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else if (w_expired) begin
                            r_err   <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else if (r_cnt != c_CNT_W'(TIMEOUT_CYCLES)) begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end

        assign w_queued[k]                    = (r_state == c_ST_QUEUED);
        assign w_aggr_all[k*AGGR_W +: AGGR_W] = r_aggr;
        assign w_id_all[k*ID_W +: ID_W]       = r_id;
        assign req_wake_o[k]                  = r_wake;
        assign req_error_o[k]                 = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_fractal_sync_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fractal_sync_rr_arb
// Purpose  : Self-checking bench for fractal_sync_rr_arb (N_REQ=4, timeout 8).
//            Contains a directed vector table, hand-written corner sequences
//            and random traffic compared against a request-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fractal_sync_rr_arb;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int IW = 5;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    sync;
    logic [N*AW-1:0] aggr;
    logic [N*IW-1:0] id;
    logic            ready;
    logic            wake;
    logic            err;
    logic [N-1:0]    dst;
    logic [N-1:0]    wake_o;
    logic [N-1:0]    err_o;
    logic            o_sync;
    logic [AW-1:0]   o_aggr;
    logic [IW-1:0]   o_id;
    logic [1:0]      o_src;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fractal_sync_rr_arb #(
        .N_REQ(N), .AGGR_W(AW), .ID_W(IW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_sync_i(sync), .req_aggr_i(aggr), .req_id_i(id),
        .req_wake_o(wake_o), .req_error_o(err_o),
        .out_sync_o(o_sync), .out_ready_i(ready),
        .out_aggr_o(o_aggr), .out_id_o(o_id), .out_src_o(o_src),
        .rsp_wake_i(wake), .rsp_error_i(err), .rsp_dst_i(dst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- request-level reference model ----------------
    typedef enum int {M_IDLE, M_QUEUED, M_ISSUED} mst_t;
    mst_t         m_st[N];
    int           m_aggr[N];
    int           m_id[N];
    int           m_dead[N];   // edge number at which the watchdog fires
    int           m_ptr;
    int           m_edge = 0;
    logic [N-1:0] m_wake;
    logic [N-1:0] m_err;

    function automatic void m_reset();
        for (int k = 0; k < N; k++) begin
            m_st[k] = M_IDLE; m_aggr[k] = 0; m_id[k] = 0; m_dead[k] = 0;
        end
        m_ptr = 0; m_wake = '0; m_err = '0;
    endfunction

    function automatic int m_win();
        for (int i = 0; i < N; i++) begin
            if (m_st[(m_ptr + i) % N] == M_QUEUED) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic check_model();
        int w;
        w = m_win();
        chk("out_sync", o_sync, w >= 0);
        chk("out_src", o_src, (w >= 0) ? w : 0);
        chk("out_id", o_id, (w >= 0) ? m_id[w] : 0);
        chk("out_aggr", o_aggr, (w >= 0) ? m_aggr[w] : 0);
        chk("req_wake", wake_o, m_wake);
        chk("req_error", err_o, m_err);
    endtask

    task automatic m_step();
        int w;
        bit hs;
        if (!rst_ni) begin
            m_reset();
            return;
        end
        w  = m_win();
        hs = (w >= 0) && ready;
        for (int k = 0; k < N; k++) begin
            m_wake[k] = 1'b0;
            m_err[k]  = sync[k] && (m_st[k] != M_IDLE);
            case (m_st[k])
                M_IDLE: if (sync[k]) begin
                    m_st[k]   = M_QUEUED;
                    m_aggr[k] = int'(aggr[k*AW +: AW]);
                    m_id[k]   = int'(id[k*IW +: IW]);
                end
                M_QUEUED: if (hs && w == k) begin
                    m_st[k]   = M_ISSUED;
                    m_dead[k] = m_edge + TO + 1;
                end
                default: begin
                    if (err && dst[k]) begin
                        m_err[k] = 1'b1; m_st[k] = M_IDLE;
                    end else if (wake && dst[k]) begin
                        m_wake[k] = 1'b1; m_st[k] = M_IDLE;
                    end else if (m_edge == m_dead[k]) begin
                        m_err[k] = 1'b1; m_st[k] = M_IDLE;
                    end
                end
            endcase
        end
        if (hs) m_ptr = (w + 1) % N;
        m_edge++;
    endtask

    // Inputs change at posedge+1; outputs are checked at posedge+2.
    task automatic settle();  #1; check_model(); endtask
    task automatic advance(); m_step(); @(posedge clk); #1; endtask
    task automatic cyc();     settle(); advance(); endtask

    task automatic drive(input logic [N-1:0] s, input logic r, input logic wk,
                         input logic er, input logic [N-1:0] d);
        sync = s; ready = r; wake = wk; err = er; dst = d;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        m_reset();
        drive('0, 1'b0, 1'b0, 1'b0, '0);
        settle();
        advance();
        rst_ni = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0] sync;
        logic         ready;
        logic         wake;
        logic         err;
        logic [N-1:0] dst;
        logic         e_sync;
        logic [1:0]   e_src;
        logic [IW-1:0] e_id;
        logic [N-1:0] e_wake;
        logic [N-1:0] e_err;
    } vec_t;

    function automatic vec_t mkv(logic [N-1:0] s, logic r, logic wk, logic er, logic [N-1:0] d,
                                 logic es, logic [1:0] esrc, logic [IW-1:0] eid,
                                 logic [N-1:0] ew, logic [N-1:0] ee);
        vec_t v;
        v.sync = s; v.ready = r; v.wake = wk; v.err = er; v.dst = d;
        v.e_sync = es; v.e_src = esrc; v.e_id = eid; v.e_wake = ew; v.e_err = ee;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        // All four requesters fire together. Then 1 and 3 are woken, and 0
        // and 2 are left to the watchdog. A late wake to 2 must be ignored.
        tbl[0]  = mkv(4'b1111, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
        tbl[1]  = mkv(4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000);
        tbl[2]  = mkv(4'b0000, 1, 0, 0, 4'b0000, 1, 1, 1, 4'b0000, 4'b0000);
        tbl[3]  = mkv(4'b0000, 1, 0, 0, 4'b0000, 1, 2, 2, 4'b0000, 4'b0000);
        tbl[4]  = mkv(4'b0000, 1, 0, 0, 4'b0000, 1, 3, 3, 4'b0000, 4'b0000);
        tbl[5]  = mkv(4'b0000, 1, 1, 0, 4'b1010, 0, 0, 0, 4'b0000, 4'b0000);
        tbl[6]  = mkv(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b1010, 4'b0000);
        tbl[7]  = mkv(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
        tbl[8]  = mkv(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
        tbl[9]  = mkv(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
        tbl[10] = mkv(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
        tbl[11] = mkv(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0001);
        tbl[12] = mkv(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
        tbl[13] = mkv(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0100);
        tbl[14] = mkv(4'b0000, 1, 1, 0, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000);
        tbl[15] = mkv(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);

        rst_ni = 1'b0;
        aggr   = '0;
        id     = '0;
        m_reset();
        drive('0, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        settle();
        chk("reset out_sync", o_sync, 0);
        chk("reset out_src", o_src, 0);
        chk("reset wake/err", {wake_o, err_o}, 0);
        advance();
        rst_ni = 1'b1;

        for (int k = 0; k < N; k++) begin
            aggr[k*AW +: AW] = AW'(1);
            id[k*IW +: IW]   = IW'(k);
        end
        for (int r = 0; r < 16; r++) begin
            drive(tbl[r].sync, tbl[r].ready, tbl[r].wake, tbl[r].err, tbl[r].dst);
            #1;
            chk($sformatf("tbl%0d out_sync", r), o_sync, tbl[r].e_sync);
            chk($sformatf("tbl%0d out_src", r), o_src, tbl[r].e_src);
            chk($sformatf("tbl%0d out_id", r), o_id, tbl[r].e_id);
            chk($sformatf("tbl%0d req_wake", r), wake_o, tbl[r].e_wake);
            chk($sformatf("tbl%0d req_error", r), err_o, tbl[r].e_err);
            check_model();
            advance();
        end

        // Backpressure: 0 and 2 queued, ready low for 5 cycles.
        do_reset();
        drive(4'b0101, 1'b0, 1'b0, 1'b0, '0); cyc();
        for (int i = 0; i < 5; i++) begin
            drive('0, 1'b0, 1'b0, 1'b0, '0);
            settle();
            chk("hold out_sync", o_sync, 1);
            chk("hold out_src", o_src, 0);
            advance();
        end
        drive('0, 1'b1, 1'b0, 1'b0, '0);
        settle(); chk("release first src", o_src, 0); advance();
        settle(); chk("release second src", o_src, 2); advance();
        drive(4'b1010, 1'b0, 1'b0, 1'b0, '0);
        settle(); chk("release drained", o_sync, 0); advance();
        drive('0, 1'b0, 1'b0, 1'b0, '0);
        settle(); chk("pointer at 3", o_src, 3); advance();
        drive('0, 1'b1, 1'b0, 1'b0, '0); cyc(); cyc();
        drive('0, 1'b0, 1'b1, 1'b0, 4'b1111); cyc();
        drive('0, 1'b0, 1'b0, 1'b0, '0); cyc();

        // Protocol violation while ISSUED, then a normal wake.
        drive(4'b0001, 1'b1, 1'b0, 1'b0, '0); cyc();
        drive('0, 1'b1, 1'b0, 1'b0, '0); cyc();
        drive(4'b0001, 1'b1, 1'b0, 1'b0, '0); cyc();
        drive('0, 1'b1, 1'b0, 1'b0, '0);
        settle();
        chk("violation error", err_o, 4'b0001);
        chk("violation no issue", o_sync, 0);
        advance();
        drive('0, 1'b1, 1'b1, 1'b0, 4'b0001); cyc();
        drive('0, 1'b1, 1'b0, 1'b0, '0);
        settle(); chk("wake after violation", wake_o, 4'b0001); advance();

        // Reset with one requester ISSUED and two QUEUED.
        drive(4'b0001, 1'b1, 1'b0, 1'b0, '0); cyc();
        drive('0, 1'b1, 1'b0, 1'b0, '0); cyc();
        drive(4'b0110, 1'b0, 1'b0, 1'b0, '0); cyc();
        drive('0, 1'b0, 1'b0, 1'b0, '0); settle();
        rst_ni = 1'b0;
        m_reset();
        #1;
        chk("midrst out_sync", o_sync, 0);
        chk("midrst fields", {o_aggr, o_id, o_src}, 0);
        chk("midrst wake/err", {wake_o, err_o}, 0);
        advance();
        advance();
        rst_ni = 1'b1;
        drive('0, 1'b1, 1'b1, 1'b0, 4'b1111);
        settle(); chk("late wake idle", o_sync, 0); advance();
        drive('0, 1'b1, 1'b0, 1'b1, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("post reset out_sync", o_sync, 0);
            chk("post reset pulses", {wake_o, err_o}, 0);
            advance();
            drive('0, 1'b1, 1'b0, 1'b0, '0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] s;
            for (int k = 0; k < N; k++) s[k] = ($urandom_range(0, 5) == 0);
            aggr = (N*AW)'({$urandom, $urandom});
            id   = (N*IW)'($urandom);
            drive(s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 11) == 0), N'($urandom));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fractal_sync_rr_arb.md
Name: fractal_sync_rr_arb

Overview:
- Shares one fractal synchronization request port among N_REQ compute-unit requesters, so several CUs can sit behind a single leaf port of a fractal_sync_1d/2d node.
- Latches one barrier request per requester and issues queued requests downstream in round-robin order.
- Routes wake and error responses back to requesters by destination mask.
- Runs a per-requester timeout watchdog that converts a lost wake into an error.

Parameters:
- N_REQ, 4, number of requesters; range 2..32.
- AGGR_W, 6, aggregate field width.
- ID_W, 5, barrier ID field width.
- TIMEOUT_CYCLES, 1024, maximum cycles a requester waits in ISSUED; 0 disables the watchdog.
- SRC_W, $clog2(N_REQ), source index width (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_sync_i  in  N_REQ  per-requester one-cycle sync request pulse.
- req_aggr_i  in  N_REQ x AGGR_W  per-requester aggregate, sampled with req_sync_i.
- req_id_i  in  N_REQ x ID_W  per-requester barrier ID, sampled with req_sync_i.
- req_wake_o  out  N_REQ  one-cycle wake pulse per requester.
- req_error_o  out  N_REQ  one-cycle error pulse per requester.
- out_sync_o  out  1  downstream request valid.
- out_ready_i  in  1  downstream accepts the request this cycle.
- out_aggr_o  out  AGGR_W  aggregate of the granted request.
- out_id_o  out  ID_W  barrier ID of the granted request.
- out_src_o  out  SRC_W  index of the granted requester.
- rsp_wake_i  in  1  downstream wake valid.
- rsp_error_i  in  1  downstream error valid.
- rsp_dst_i  in  N_REQ  destination mask for rsp_wake_i / rsp_error_i.

Behaviour:
- Reset (async assert, sync release):
  - all requester FSMs IDLE; RR pointer 0; timeout counters 0.
  - req_wake_o, req_error_o, out_sync_o all 0; out_aggr_o, out_id_o, out_src_o all 0.
- Per-requester FSM: IDLE -> QUEUED -> ISSUED -> IDLE.
  - IDLE: req_sync_i[k]=1 latches aggr and id, next state QUEUED.
  - QUEUED: eligible for arbitration. When granted and out_ready_i=1, next state ISSUED and the timeout counter clears.
  - ISSUED: waits for a wake. When rsp_wake_i=1 and rsp_dst_i[k]=1, req_wake_o[k]=1 in the next cycle and next state IDLE.
- Protocol violation: req_sync_i[k]=1 while not IDLE drops the request; req_error_o[k]=1 next cycle; state unchanged.
- Arbitration:
  - Combinational over QUEUED requesters.
  - Search starts at the RR pointer and wraps from N_REQ-1 to 0.
  - out_sync_o=1 when any requester is QUEUED. out_aggr_o, out_id_o, out_src_o come from the winner; all 0 when none is QUEUED.
  - On handshake (out_sync_o && out_ready_i), pointer <= (winner+1) mod N_REQ.
  - Without a handshake, pointer and winner hold; request fields stay stable while out_ready_i=0.
- Latency:
  - req_sync_i at cycle t gives out_sync_o at t+1 at the earliest.
  - Response at cycle w gives req_wake_o or req_error_o at w+1.
  - At most one downstream issue per cycle.
- Downstream error: rsp_error_i=1 with rsp_dst_i[k]=1 and requester k ISSUED gives req_error_o[k]=1 next cycle; next state IDLE.
  - If rsp_wake_i and rsp_error_i are both set for the same k, error wins.
- Unexpected response: mask bits for requesters not in ISSUED are ignored, with no output pulse. A multi-bit mask wakes every ISSUED requester selected.
- Watchdog (TIMEOUT_CYCLES>0): the counter increments each cycle in ISSUED. When it reaches TIMEOUT_CYCLES, req_error_o[k]=1 next cycle and next state IDLE.
  - A wake or error in the same cycle as expiry takes precedence: wake is reported, not timeout.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- Same-cycle return and re-request: wake pulse and new req_sync_i[k] in the same cycle is legal only once req_wake_o[k] has been seen. A request in the wake-output cycle is accepted because the state is already IDLE.
- Reset mid-operation: all in-flight state is discarded. Late downstream responses after reset are ignored because no requester is ISSUED.

Test Plan:
- N_REQ=4, out_ready_i=1, all four pulse req_sync_i in the same cycle with id=k, aggr=1.
  -> out_src_o sequence 0,1,2,3 on consecutive cycles starting t+1; out_id_o matches.
- Requesters 1 and 3 issued, then rsp_wake_i=1 with rsp_dst_i=4'b1010.
  -> req_wake_o=4'b1010 for exactly one cycle, one cycle later; both return to IDLE.
- out_ready_i held 0 for 5 cycles with requesters 0 and 2 QUEUED.
  -> out_sync_o=1 and out_src_o=0 stable for 5 cycles; after release, 0 is issued, then 2 the next cycle; pointer ends at 3.
- TIMEOUT_CYCLES=8, requester 2 issued, no response.
  -> req_error_o[2]=1 exactly 9 cycles after the issue edge; a later wake with dst=4'b0100 produces no req_wake_o.
- Requester 0 pulses req_sync_i again while ISSUED.
  -> req_error_o[0]=1 next cycle; no downstream issue. A subsequent wake still produces req_wake_o[0]=1.
- rst_ni asserted while two requesters are QUEUED and one is ISSUED.
  -> all outputs 0 immediately; after release out_sync_o stays 0 until a new req_sync_i.
